// File: rtl/regfile_mp.sv
// Multi-ported register file with write-through bypass and a per-register busy
// scoreboard used by decode to detect RAW hazards on both ALU operands.
module regfile_mp #(
  parameter int WIDTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd1_en,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic [WIDTH-1:0]  rd1_data,
  output logic              rd1_busy,
  input  logic              rd2_en,
  input  logic [ADDR_W-1:0] rd2_addr,
  output logic [WIDTH-1:0]  rd2_data,
  output logic              rd2_busy,
  input  logic              bsy_set,
  input  logic [ADDR_W-1:0] bsy_addr,
  output logic              any_busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  mem_d [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic              any_busy_q;
  logic              any_busy_d;

  logic              wr_ok;
  logic              set_ok;
  logic [1:0]        rd_en;
  logic [ADDR_W-1:0] rd_addr [2];
  logic [WIDTH-1:0]  rd_data [2];
  logic [1:0]        rd_busy;

  // Writes and sets are gated by reset so a held reset also blanks the bypass path.
  assign wr_ok  = rst && wr_en && !(ZERO_REG != 0 && wr_addr == '0);
  assign set_ok = rst && bsy_set && !(ZERO_REG != 0 && bsy_addr == '0);

  always_comb begin
    mem_d = mem_q;
    if (wr_ok) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  // Set is applied after clear so a producer issuing as the old one retires keeps the bit.
  always_comb begin
    busy_d = busy_q;
    if (wr_ok) begin
      busy_d[wr_addr] = 1'b0;
    end
    if (set_ok) begin
      busy_d[bsy_addr] = 1'b1;
    end
    any_busy_d = |busy_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      busy_q     <= '0;
      any_busy_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      busy_q     <= busy_d;
      any_busy_q <= any_busy_d;
    end
  end

  assign rd_en      = {rd2_en, rd1_en};
  assign rd_addr[0] = rd1_addr;
  assign rd_addr[1] = rd2_addr;

  // A forwarded write resolves the hazard, so the bypass path never reports busy.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = '0;
      rd_busy[p] = 1'b0;
      if (rst && rd_en[p] && !(ZERO_REG != 0 && rd_addr[p] == '0)) begin
        if (BYPASS != 0 && wr_ok && wr_addr == rd_addr[p]) begin
          rd_data[p] = wr_data;
        end else begin
          rd_data[p] = mem_q[rd_addr[p]];
          rd_busy[p] = busy_q[rd_addr[p]];
        end
      end
    end
  end

  assign rd1_data = rd_data[0];
  assign rd2_data = rd_data[1];
  assign rd1_busy = rd_busy[0];
  assign rd2_busy = rd_busy[1];
  assign any_busy = any_busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: three configurations share one stimulus stream and are
// checked against an array-based model of the register file and scoreboard.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        rd1_en;
  logic [3:0]  rd1_addr;
  logic        rd2_en;
  logic [3:0]  rd2_addr;
  logic        bsy_set;
  logic [3:0]  bsy_addr;

  logic [2:0][15:0] rd1_d;
  logic [2:0][15:0] rd2_d;
  logic [2:0]       rd1_b;
  logic [2:0]       rd2_b;
  logic [2:0]       anyb;

  int n_tests = 0;
  int n_fail  = 0;

  // Instance c has ZERO_REG = zr[c] and BYPASS = byp[c].
  int zr[3]  = '{1, 1, 0};
  int byp[3] = '{1, 0, 1};

  logic [15:0] m_mem[3][16];
  bit          m_busy[3][16];

  always #5 clk = ~clk;

  regfile_mp #(.WIDTH(16), .ADDR_W(4), .ZERO_REG(1), .BYPASS(1)) u_dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(rd1_d[0]), .rd1_busy(rd1_b[0]),
    .rd2_en(rd2_en), .rd2_addr(rd2_addr), .rd2_data(rd2_d[0]), .rd2_busy(rd2_b[0]),
    .bsy_set(bsy_set), .bsy_addr(bsy_addr), .any_busy(anyb[0])
  );

  regfile_mp #(.WIDTH(16), .ADDR_W(4), .ZERO_REG(1), .BYPASS(0)) u_dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(rd1_d[1]), .rd1_busy(rd1_b[1]),
    .rd2_en(rd2_en), .rd2_addr(rd2_addr), .rd2_data(rd2_d[1]), .rd2_busy(rd2_b[1]),
    .bsy_set(bsy_set), .bsy_addr(bsy_addr), .any_busy(anyb[1])
  );

  regfile_mp #(.WIDTH(16), .ADDR_W(4), .ZERO_REG(0), .BYPASS(1)) u_dut2 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(rd1_d[2]), .rd1_busy(rd1_b[2]),
    .rd2_en(rd2_en), .rd2_addr(rd2_addr), .rd2_data(rd2_d[2]), .rd2_busy(rd2_b[2]),
    .bsy_set(bsy_set), .bsy_addr(bsy_addr), .any_busy(anyb[2])
  );

  function automatic bit wr_qual(int c);
    return rst === 1'b1 && wr_en === 1'b1 && !(zr[c] == 1 && wr_addr == 4'd0);
  endfunction

  function automatic bit set_qual(int c);
    return rst === 1'b1 && bsy_set === 1'b1 && !(zr[c] == 1 && bsy_addr == 4'd0);
  endfunction

  function automatic logic [15:0] exp_data(int c, logic en, logic [3:0] a);
    if (rst !== 1'b1 || en !== 1'b1) return 16'h0000;
    if (zr[c] == 1 && a == 4'd0) return 16'h0000;
    if (byp[c] == 1 && wr_qual(c) && wr_addr == a) return wr_data;
    return m_mem[c][a];
  endfunction

  function automatic logic exp_busy(int c, logic en, logic [3:0] a);
    if (rst !== 1'b1 || en !== 1'b1) return 1'b0;
    if (zr[c] == 1 && a == 4'd0) return 1'b0;
    if (byp[c] == 1 && wr_qual(c) && wr_addr == a) return 1'b0;
    return m_busy[c][a];
  endfunction

  function automatic logic exp_any(int c);
    logic r = 1'b0;
    for (int a = 0; a < 16; a++) r = r | m_busy[c][a];
    return r;
  endfunction

  task automatic clear_model();
    for (int c = 0; c < 3; c++)
      for (int a = 0; a < 16; a++) begin
        m_mem[c][a]  = 16'h0000;
        m_busy[c][a] = 1'b0;
      end
  endtask

  task automatic model_edge();
    for (int c = 0; c < 3; c++) begin
      if (wr_qual(c)) begin
        m_mem[c][wr_addr]  = wr_data;
        m_busy[c][wr_addr] = 1'b0;
      end
      if (set_qual(c)) m_busy[c][bsy_addr] = 1'b1;
    end
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_addr = 4'd0; wr_data = 16'h0000;
    rd1_en = 1'b0; rd1_addr = 4'd0; rd2_en = 1'b0; rd2_addr = 4'd0;
    bsy_set = 1'b0; bsy_addr = 4'd0;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++) begin
      n_tests++;
      if (anyb[c] !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL reset_any cfg=%0d got=%b exp=0", c, anyb[c]);
      end
    end
    rst = 1'b1;
    #1;
    for (int a = 0; a < 16; a++) begin
      rd1_en = 1'b1; rd2_en = 1'b1;
      rd1_addr = 4'(a); rd2_addr = 4'(15 - a);
      #1;
      for (int c = 0; c < 3; c++) begin
        n_tests++;
        if (rd1_d[c] !== 16'h0000 || rd2_d[c] !== 16'h0000 ||
            rd1_b[c] !== 1'b0 || rd2_b[c] !== 1'b0 || anyb[c] !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL reset_read cfg=%0d addr=%0d got=%h/%h/%b/%b/%b exp=0", c, a,
                   rd1_d[c], rd2_d[c], rd1_b[c], rd2_b[c], anyb[c]);
        end
      end
    end
    idle();
    step();
  endtask

  task automatic test_write_read();
    idle();
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'hBEEF;
    step();
    idle();
    rd1_en = 1'b1; rd1_addr = 4'd5; rd2_en = 1'b1; rd2_addr = 4'd5;
    #1;
    for (int c = 0; c < 3; c++) begin
      n_tests++;
      if (rd1_d[c] !== 16'hBEEF || rd2_d[c] !== 16'hBEEF) begin
        n_fail++;
        $display("[TB] FAIL write_read cfg=%0d got=%h/%h exp=beef", c, rd1_d[c], rd2_d[c]);
      end
    end
    rd1_en = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      n_tests++;
      if (rd1_d[c] !== 16'h0000 || rd2_d[c] !== 16'hBEEF) begin
        n_fail++;
        $display("[TB] FAIL read_disable cfg=%0d got=%h/%h exp=0000/beef", c, rd1_d[c], rd2_d[c]);
      end
    end
    step();
  endtask

  task automatic test_bypass();
    logic [15:0] exp;
    idle();
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h1234;
    rd2_en = 1'b1; rd2_addr = 4'd7;
    #1;
    for (int c = 0; c < 3; c++) begin
      exp = (byp[c] == 1) ? 16'h1234 : 16'h0000;
      n_tests++;
      if (rd2_d[c] !== exp) begin
        n_fail++;
        $display("[TB] FAIL bypass_same_cycle cfg=%0d got=%h exp=%h", c, rd2_d[c], exp);
      end
    end
    step();
    wr_en = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      n_tests++;
      if (rd2_d[c] !== 16'h1234) begin
        n_fail++;
        $display("[TB] FAIL bypass_next_cycle cfg=%0d got=%h exp=1234", c, rd2_d[c]);
      end
    end
    step();
  endtask

  task automatic test_zero_reg();
    logic [15:0] exp_d;
    logic        exp_b;
    idle();
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hFFFF;
    bsy_set = 1'b1; bsy_addr = 4'd0;
    step();
    idle();
    rd1_en = 1'b1; rd1_addr = 4'd0; rd2_en = 1'b1; rd2_addr = 4'd0;
    for (int k = 0; k < 3; k++) begin
      #1;
      for (int c = 0; c < 3; c++) begin
        exp_d = (zr[c] == 1) ? 16'h0000 : 16'hFFFF;
        exp_b = (zr[c] == 1) ? 1'b0 : 1'b1;
        n_tests++;
        if (rd1_d[c] !== exp_d || rd2_d[c] !== exp_d || rd1_b[c] !== exp_b ||
            rd2_b[c] !== exp_b || anyb[c] !== exp_b) begin
          n_fail++;
          $display("[TB] FAIL zero_reg cfg=%0d got=%h/%h/%b/%b/%b exp=%h busy=%b", c,
                   rd1_d[c], rd2_d[c], rd1_b[c], rd2_b[c], anyb[c], exp_d, exp_b);
        end
      end
      step();
    end
    // Retire the r0 producer in the configuration that has a real r0.
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'h0000;
    step();
  endtask

  task automatic test_scoreboard();
    logic [15:0] exp_d;
    logic        exp_b;
    idle();
    bsy_set = 1'b1; bsy_addr = 4'd3;
    step();
    idle();
    rd1_en = 1'b1; rd1_addr = 4'd3;
    #1;
    for (int c = 0; c < 3; c++) begin
      n_tests++;
      if (rd1_b[c] !== 1'b1 || anyb[c] !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL busy_set cfg=%0d got=%b/%b exp=1/1", c, rd1_b[c], anyb[c]);
      end
    end
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'h00AA;
    #1;
    for (int c = 0; c < 3; c++) begin
      exp_d = (byp[c] == 1) ? 16'h00AA : m_mem[c][3];
      exp_b = (byp[c] == 1) ? 1'b0 : 1'b1;
      n_tests++;
      if (rd1_d[c] !== exp_d || rd1_b[c] !== exp_b) begin
        n_fail++;
        $display("[TB] FAIL busy_resolve cfg=%0d got=%h/%b exp=%h/%b", c, rd1_d[c], rd1_b[c], exp_d, exp_b);
      end
    end
    step();
    wr_en = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      n_tests++;
      if (rd1_d[c] !== 16'h00AA || rd1_b[c] !== 1'b0 || anyb[c] !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL busy_clear cfg=%0d got=%h/%b/%b exp=00aa/0/0", c, rd1_d[c], rd1_b[c], anyb[c]);
      end
    end
    bsy_set = 1'b1; bsy_addr = 4'd3;
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'h0055;
    step();
    idle();
    rd1_en = 1'b1; rd1_addr = 4'd3;
    #1;
    for (int c = 0; c < 3; c++) begin
      n_tests++;
      if (rd1_d[c] !== 16'h0055 || rd1_b[c] !== 1'b1 || anyb[c] !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL set_wins cfg=%0d got=%h/%b/%b exp=0055/1/1", c, rd1_d[c], rd1_b[c], anyb[c]);
      end
    end
    step();
  endtask

  task automatic test_async_reset();
    idle();
    for (int a = 1; a < 16; a++) begin
      wr_en = 1'b1; wr_addr = 4'(a); wr_data = 16'hA5A5;
      step();
    end
    idle();
    bsy_set = 1'b1; bsy_addr = 4'd4;
    step();
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 4'd6; wr_data = 16'h7777;
    rd1_en = 1'b1; rd1_addr = 4'd6; rd2_en = 1'b1; rd2_addr = 4'd4;
    bsy_set = 1'b1; bsy_addr = 4'd9;
    #1;
    rst = 1'b0;
    clear_model();
    #1;
    for (int c = 0; c < 3; c++) begin
      n_tests++;
      if (rd1_d[c] !== 16'h0000 || rd2_d[c] !== 16'h0000 || rd1_b[c] !== 1'b0 ||
          rd2_b[c] !== 1'b0 || anyb[c] !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL async_reset cfg=%0d got=%h/%h/%b/%b/%b exp=0", c,
                 rd1_d[c], rd2_d[c], rd1_b[c], rd2_b[c], anyb[c]);
      end
    end
    @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++) begin
      n_tests++;
      if (rd1_d[c] !== 16'h0000 || rd2_b[c] !== 1'b0 || anyb[c] !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL reset_held cfg=%0d got=%h/%b/%b exp=0", c, rd1_d[c], rd2_b[c], anyb[c]);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    idle();
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'h0001;
    step();
    idle();
    rd1_en = 1'b1; rd1_addr = 4'd2; rd2_en = 1'b1; rd2_addr = 4'd1;
    #1;
    for (int c = 0; c < 3; c++) begin
      n_tests++;
      if (rd1_d[c] !== 16'h0001 || rd2_d[c] !== 16'h0000 || anyb[c] !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL after_reset cfg=%0d got=%h/%h/%b exp=0001/0000/0", c, rd1_d[c], rd2_d[c], anyb[c]);
      end
    end
    step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      wr_en    = 1'($urandom_range(0, 1));
      wr_addr  = 4'($urandom_range(0, 7));
      wr_data  = 16'($urandom);
      bsy_set  = 1'($urandom_range(0, 1));
      bsy_addr = 4'($urandom_range(0, 7));
      rd1_en   = ($urandom_range(0, 7) != 0);
      rd1_addr = 4'($urandom_range(0, 7));
      rd2_en   = ($urandom_range(0, 7) != 0);
      rd2_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom_range(0, 15));
      #1;
      for (int c = 0; c < 3; c++) begin
        n_tests++;
        if (rd1_d[c] !== exp_data(c, rd1_en, rd1_addr) || rd1_b[c] !== exp_busy(c, rd1_en, rd1_addr) ||
            rd2_d[c] !== exp_data(c, rd2_en, rd2_addr) || rd2_b[c] !== exp_busy(c, rd2_en, rd2_addr) ||
            anyb[c] !== exp_any(c)) begin
          n_fail++;
          $display("[TB] FAIL random cfg=%0d iter=%0d got=%h/%b %h/%b any=%b exp=%h/%b %h/%b any=%b",
                   c, i, rd1_d[c], rd1_b[c], rd2_d[c], rd2_b[c], anyb[c],
                   exp_data(c, rd1_en, rd1_addr), exp_busy(c, rd1_en, rd1_addr),
                   exp_data(c, rd2_en, rd2_addr), exp_busy(c, rd2_en, rd2_addr), exp_any(c));
        end
      end
      step();
    end
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    clear_model();
    #2;
    test_reset();
    test_write_read();
    test_bypass();
    test_zero_reg();
    test_scoreboard();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
